uart_transmitter: RTL and testbench

UART 8N1-style serial transmitter, the TX counterpart of the board's UART receiver; drives the FPGA TX pin to the host USB-UART bridge. Accepts parallel bytes via valid/ready handshake into a one-byte holding register, serialises LSB-first with start/stop framing. Baud timing comes from an internal clock-enable counter on i_clk, so no derived clocks. The holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_transmitter_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_transmitter.sv | 143 ++++++++++++++
 tb/tb_uart_transmitter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding, common baud divisors at 12 MHz
// and the idle line level. The matching receiver imports the same package.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int CLKS_PER_BIT_9600   = 1250;
    localparam int CLKS_PER_BIT_115200 = 104;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period clock enable: counts 0..CLKS_PER_BIT-1 while not cleared and
// flags the final count of each bit period with o_tick.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == CNT_LAST) && !i_clear;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one-byte holding register in front of an LSB-first
// start/data/stop serialiser, paced by a clock-enable baud counter.
//
// Handshake: a byte is accepted on any rising edge where i_valid && o_ready;
// i_valid is ignored and i_data is not sampled while o_ready is low, and
// i_valid may be held high across edges to queue successive bytes.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 tick;

    // The counter sits at zero in IDLE; every other state change lands on a
    // wrap, so the bit period always restarts cleanly.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clear(state_q == ST_IDLE),
        .o_tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idx_d       = idx_q;
        stop_idx_d  = stop_idx_q;
        tx_d        = tx_q;

        if (i_valid && !hold_full_q) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
        end

        // tx_d anticipates the next state so the pin comes straight from a flop.
        case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = ST_START;
                    tx_d        = ~LINE_IDLE;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = LINE_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // A held byte chains straight into the next start bit.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = ST_START;
                            tx_d        = ~LINE_IDLE;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = LINE_IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            idx_q       <= '0;
            stop_idx_q  <= 1'b0;
            tx_q        <= LINE_IDLE;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idx_q       <= idx_d;
            stop_idx_q  <= stop_idx_d;
            tx_q        <= tx_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = !hold_full_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_STOP) && (stop_idx_q == STOP_LAST) && tick;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: an 8N1 instance (4 clocks/bit) and a 7-bit,
// 2-stop instance (3 clocks/bit), checked against a frame-schedule model.
module tb_uart_transmitter;

    localparam int CPB_A = 4;
    localparam int DB_A  = 8;
    localparam int SB_A  = 1;
    localparam int CPB_B = 3;
    localparam int DB_B  = 7;
    localparam int SB_B  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n = 1'b1;
    logic       rst_b_n = 1'b1;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic [7:0] data_a  = '0;
    logic [6:0] data_b  = '0;
    logic       tx_a, ready_a, busy_a, done_a;
    logic       tx_b, ready_b, busy_b, done_b;

    uart_transmitter #(
        .CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A), .STOP_BITS(SB_A)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_a_n), .i_data(data_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
    );

    uart_transmitter #(
        .CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B), .STOP_BITS(SB_B)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .i_data(data_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // sched[id] holds the line level for every remaining cycle of the current
    // frame; the frame is built bit by bit from the framing rules.
    bit         sched  [2][$];
    bit         m_full [2];
    logic [7:0] m_hold [2];
    bit         m_acc  [2];
    logic [7:0] exp_q[$];

    function automatic int cpb(input int id);
        return (id == 0) ? CPB_A : CPB_B;
    endfunction
    function automatic int nbits(input int id);
        return (id == 0) ? DB_A : DB_B;
    endfunction
    function automatic int nstop(input int id);
        return (id == 0) ? SB_A : SB_B;
    endfunction

    task automatic push_frame(input int id, input logic [7:0] b);
        for (int c = 0; c < cpb(id); c++) sched[id].push_back(1'b0);
        for (int i = 0; i < nbits(id); i++)
            for (int c = 0; c < cpb(id); c++) sched[id].push_back(b[i]);
        for (int c = 0; c < nstop(id) * cpb(id); c++) sched[id].push_back(1'b1);
    endtask

    task automatic model_reset(input int id);
        sched[id].delete();
        m_full[id] = 1'b0;
        m_acc[id]  = 1'b0;
    endtask

    task automatic model_edge(input int id, input bit v, input logic [7:0] d);
        bit was_full;
        was_full = m_full[id];
        if (sched[id].size() != 0) void'(sched[id].pop_front());
        if (sched[id].size() == 0 && was_full) begin
            push_frame(id, m_hold[id]);
            m_full[id] = 1'b0;
        end
        m_acc[id] = v && !was_full;
        if (m_acc[id]) begin
            m_full[id] = 1'b1;
            m_hold[id] = d;
            if (id == 1) exp_q.push_back(d);
        end
    endtask

    always @(posedge clk or negedge rst_a_n)
        if (!rst_a_n) model_reset(0);
        else          model_edge(0, valid_a, data_a);

    always @(posedge clk or negedge rst_b_n)
        if (!rst_b_n) model_reset(1);
        else          model_edge(1, valid_b, {1'b0, data_b});

    // ---------------- per-cycle compare ----------------
    task automatic cmp_dut(input int id, input logic tx, input logic rdy,
                           input logic bsy, input logic dn);
        int n;
        n = sched[id].size();
        chk($sformatf("dut%0d_tx", id), tx, (n != 0) ? sched[id][0] : 1'b1);
        chk($sformatf("dut%0d_ready", id), rdy, !m_full[id]);
        chk($sformatf("dut%0d_busy", id), bsy, n != 0);
        chk($sformatf("dut%0d_done", id), dn, n == 1);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut(0, tx_a, ready_a, busy_a, done_a);
            cmp_dut(1, tx_b, ready_b, busy_b, done_b);
        end
    end

    // ---------------- waveform recorder for literal checks ----------------
    bit log_tx   [2][$];
    bit log_busy [2][$];
    bit log_done [2][$];
    bit rec_en   [2];

    always @(negedge clk) begin
        if (rec_en[0]) begin
            log_tx[0].push_back(tx_a); log_busy[0].push_back(busy_a); log_done[0].push_back(done_a);
        end
        if (rec_en[1]) begin
            log_tx[1].push_back(tx_b); log_busy[1].push_back(busy_b); log_done[1].push_back(done_b);
        end
    end

    task automatic start_log(input int id);
        #1;
        log_tx[id].delete(); log_busy[id].delete(); log_done[id].delete();
        rec_en[id] = 1'b1;
    endtask

    task automatic stop_log(input int id);
        #1;
        rec_en[id] = 1'b0;
    endtask

    // sel: 0 = tx, 1 = busy, 2 = done
    function automatic int count_ones(input int id, input int sel, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            if (sel == 0 && log_tx[id][i])   n++;
            if (sel == 1 && log_busy[id][i]) n++;
            if (sel == 2 && log_done[id][i]) n++;
        end
        return n;
    endfunction

    function automatic int nth_done(input int id, input int nth);
        int seen;
        seen = 0;
        for (int i = 0; i < log_done[id].size(); i++) begin
            if (log_done[id][i]) begin
                if (seen == nth) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    // ---------------- loopback receiver on the 7-bit instance ----------------
    bit         rx_act   = 1'b0;
    bit         rx_prev  = 1'b1;
    bit         rx_ok    = 1'b1;
    int         rx_cnt   = 0;
    int         rx_count = 0;
    logic [7:0] rx_bits  = '0;

    always @(negedge clk) begin
        if (!rst_b_n) begin
            rx_act  = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (rx_act) begin
                rx_cnt++;
                if (rx_cnt == 1 && tx_b !== 1'b0) rx_ok = 1'b0;
                for (int j = 1; j <= DB_B; j++)
                    if (rx_cnt == CPB_B * j + 1) rx_bits[j-1] = tx_b;
                for (int j = DB_B + 1; j <= DB_B + SB_B; j++)
                    if (rx_cnt == CPB_B * j + 1 && tx_b !== 1'b1) rx_ok = 1'b0;
                if (rx_cnt == (1 + DB_B + SB_B) * CPB_B - 1) begin
                    rx_act = 1'b0;
                    rx_count++;
                    chk("rx_framing", rx_ok, 1'b1);
                    chk("rx_pending", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("rx_byte", rx_bits, exp_q.pop_front());
                end
            end else if (tx_b === 1'b0 && rx_prev) begin
                rx_act  = 1'b1;
                rx_cnt  = 0;
                rx_ok   = 1'b1;
                rx_bits = '0;
            end
            rx_prev = tx_b;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_acc(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_acc[id] && n < 500);
        if (!m_acc[id]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: actual=no handshake required=handshake", id);
        end
    endtask

    task automatic send_a(input logic [7:0] b);
        valid_a = 1'b1;
        data_a  = b;
        wait_acc(0);
    endtask

    bit a5_pat [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit p55_pat[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        cmp_en  = 1'b1;

        // reset held while valid toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_a = i[0];
            valid_b = i[0];
            data_a  = 8'(i * 17 + 3);
            data_b  = 7'(i * 9 + 1);
        end
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        #2;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (3) @(negedge clk);

        // single byte 0xA5
        send_a(8'hA5);
        valid_a = 1'b0;
        start_log(0);
        repeat (46) @(negedge clk);
        stop_log(0);
        chk("a5_first_low", log_tx[0][0], 1'b0);
        for (int j = 0; j < 10; j++)
            chk($sformatf("a5_bit%0d_ones", j), count_ones(0, 0, 4 * j, 4 * j + 3), a5_pat[j] ? 4 : 0);
        chk("a5_done_count", count_ones(0, 2, 0, 45), 1);
        chk("a5_done_cycle", nth_done(0, 0), 39);
        chk("a5_busy_frame", count_ones(0, 1, 0, 39), 40);
        chk("a5_idle_after", count_ones(0, 0, 40, 45) + count_ones(0, 1, 40, 45), 6);

        // back-to-back 0x00 then 0xFF
        send_a(8'h00);
        start_log(0);
        data_a = 8'hFF;
        wait_acc(0);
        valid_a = 1'b0;
        repeat (85) @(negedge clk);
        stop_log(0);
        chk("b2b_done_count", count_ones(0, 2, 0, 85), 2);
        chk("b2b_done0_cycle", nth_done(0, 0), 39);
        chk("b2b_done1_cycle", nth_done(0, 1), 79);
        chk("b2b_stop_ones", count_ones(0, 0, 36, 39), 4);
        chk("b2b_second_start", count_ones(0, 0, 40, 43), 0);
        chk("b2b_ff_data", count_ones(0, 0, 44, 75), 32);
        chk("b2b_busy_len", count_ones(0, 1, 0, 85), 80);

        // backpressure: valid held high with data changing every cycle
        valid_a = 1'b1;
        for (int i = 0; i < 150; i++) begin
            data_a = 8'(i * 37 + 11);
            @(negedge clk);
        end
        valid_a = 1'b0;
        repeat (100) @(negedge clk);

        // reset mid-frame during data bit 3 of 0x3C with 0x81 held
        send_a(8'h3C);
        start_log(0);
        data_a = 8'h81;
        wait_acc(0);
        valid_a = 1'b0;
        repeat (16) @(negedge clk);
        #2;
        chk("midrst_pre_tx", tx_a, 1'b1);
        chk("midrst_pre_ready", ready_a, 1'b0);
        chk("midrst_pre_busy", busy_a, 1'b1);
        rst_a_n = 1'b0;
        #1;
        chk("midrst_tx", tx_a, 1'b1);
        chk("midrst_ready", ready_a, 1'b1);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_done", done_a, 1'b0);
        rec_en[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_a_n = 1'b1;
        start_log(0);
        repeat (60) @(negedge clk);
        stop_log(0);
        chk("postrst_line_high", count_ones(0, 0, 0, 59), 60);
        chk("postrst_busy", count_ones(0, 1, 0, 59), 0);
        chk("postrst_done", count_ones(0, 2, 0, 59), 0);

        // 7 data bits, 2 stop bits, 3 clocks per bit: 0x55
        valid_b = 1'b1;
        data_b  = 7'h55;
        wait_acc(1);
        valid_b = 1'b0;
        start_log(1);
        repeat (34) @(negedge clk);
        stop_log(1);
        for (int j = 0; j < 10; j++)
            chk($sformatf("p55_bit%0d_ones", j), count_ones(1, 0, 3 * j, 3 * j + 2), p55_pat[j] ? 3 : 0);
        chk("p55_stop_len", count_ones(1, 0, 24, 29), 6);
        chk("p55_done_cycle", nth_done(1, 0), 29);
        chk("p55_done_count", count_ones(1, 2, 0, 33), 1);
        chk("p55_busy_len", count_ones(1, 1, 0, 33), 30);

        // loopback of every 7-bit value, queued back to back
        valid_b = 1'b1;
        for (int v = 0; v < 128; v++) begin
            data_b = 7'(v);
            wait_acc(1);
        end
        valid_b = 1'b0;
        repeat (100) @(negedge clk);
        chk("rx_frames", rx_count, 129);
        chk("rx_leftover", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
